// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   state_t    : scheduler FSM state encoding (3 bits)
//   DATA_W_DEF : default byte width for FIFO and transmitter data
package uart_tx_sched_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    LATCH     = 3'd2,
    WRITE     = 3'd3,
    WAIT_BUSY = 3'd4,
    WAIT_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arb2.sv
// Two-request round-robin arbiter, purely combinational.
//   req       : request vector, bit N = source N has data
//   last      : source served most recently
//   gnt_valid : at least one request present
//   gnt       : granted source index (only meaningful when gnt_valid)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;  // tie goes to the source not served last
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules bytes from two non-showahead FIFOs onto a single UART transmitter.
//   clk_50m, reset_n          : clock, asynchronous active-low reset
//   enable                    : permits new byte grants
//   err_clr                   : clears the sticky timeout flag
//   fifoN_empty / fifoN_q     : source FIFO status and read data
//   fifoN_rdreq               : single-cycle FIFO read strobes
//   tx_busy                   : transmitter busy
//   tx_wr_en / tx_data        : transmitter load strobe and byte
//   tx_src                    : source of the current/last byte
//   byte_cnt                  : completed-byte counter (wraps)
//   err_timeout               : transmitter never acknowledged a load
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned BUSY_WAIT = 8,
  parameter int unsigned DATA_W    = DATA_W_DEF
) (
  input  logic              clk_50m,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              fifo0_empty,
  input  logic              fifo1_empty,
  input  logic [DATA_W-1:0] fifo0_q,
  input  logic [DATA_W-1:0] fifo1_q,
  output logic              fifo0_rdreq,
  output logic              fifo1_rdreq,
  input  logic              tx_busy,
  output logic              tx_wr_en,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_src,
  output logic [15:0]       byte_cnt,
  output logic              err_timeout
);

  localparam int unsigned CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUSY_WAIT - 1);

  state_t           state, state_nxt;
  logic             gnt_valid, gnt;
  logic             last_src;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]      byte_cnt_q;
  logic             grant_take, timeout_hit, byte_done;

  rr_arb2 u_arb (
    .req       ({~fifo1_empty, ~fifo0_empty}),
    .last      (last_src),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Strobes are decoded from the registered state, so reset removes them
  // immediately and they cannot glitch on release.
  always_comb begin
    state_nxt   = state;
    fifo0_rdreq = 1'b0;
    fifo1_rdreq = 1'b0;
    tx_wr_en    = 1'b0;
    grant_take  = 1'b0;
    timeout_hit = 1'b0;
    byte_done   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && !tx_busy && gnt_valid) begin
          grant_take = 1'b1;
          state_nxt  = READ;
        end
      end
      READ: begin
        fifo0_rdreq = ~tx_src;
        fifo1_rdreq = tx_src;
        state_nxt   = LATCH;
      end
      LATCH: state_nxt = WRITE;
      WRITE: begin
        tx_wr_en  = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          byte_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      tx_src      <= 1'b0;
      last_src    <= 1'b1;
      tx_data     <= '0;
      wait_cnt    <= '0;
      byte_cnt_q  <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (grant_take) begin
        tx_src   <= gnt;
        last_src <= gnt;
      end
      if (state == LATCH) tx_data <= tx_src ? fifo1_q : fifo0_q;
      if (state == WAIT_BUSY && !tx_busy && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
      else                                                wait_cnt <= '0;
      if (byte_done) byte_cnt_q <= byte_cnt_q + 16'd1;
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  import uart_tx_sched_pkg::*;

  logic        clk_50m = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic        err_clr = 1'b0;
  logic        fifo0_empty, fifo1_empty;
  logic [7:0]  fifo0_q = 8'h00, fifo1_q = 8'h00;
  logic        fifo0_rdreq, fifo1_rdreq;
  logic        tx_busy = 1'b0;
  logic        tx_wr_en;
  logic [7:0]  tx_data;
  logic        tx_src;
  logic [15:0] byte_cnt;
  logic        err_timeout;

  int vectors = 0;
  int miscompares = 0;

  uart_tx_sched #(.BUSY_WAIT(8), .DATA_W(8)) dut (
    .clk_50m     (clk_50m),
    .reset_n     (reset_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .fifo0_empty (fifo0_empty),
    .fifo1_empty (fifo1_empty),
    .fifo0_q     (fifo0_q),
    .fifo1_q     (fifo1_q),
    .fifo0_rdreq (fifo0_rdreq),
    .fifo1_rdreq (fifo1_rdreq),
    .tx_busy     (tx_busy),
    .tx_wr_en    (tx_wr_en),
    .tx_data     (tx_data),
    .tx_src      (tx_src),
    .byte_cnt    (byte_cnt),
    .err_timeout (err_timeout)
  );

  always #10 clk_50m = ~clk_50m;

  // Non-showahead FIFO models: q updates on the edge that samples rdreq.
  logic [7:0] mem0 [0:63];
  logic [7:0] mem1 [0:63];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  assign fifo0_empty = (rd0 == wr0);
  assign fifo1_empty = (rd1 == wr1);

  always @(posedge clk_50m) begin
    if (fifo0_rdreq) begin
      fifo0_q <= mem0[rd0[5:0]];
      rd0     <= rd0 + 1;
    end
    if (fifo1_rdreq) begin
      fifo1_q <= mem1[rd1[5:0]];
      rd1     <= rd1 + 1;
    end
  end

  // Transmitter model: busy rises the cycle after wr_en and lasts busy_len cycles.
  int busy_len = 10;
  int busy_left = 0;
  always @(posedge clk_50m) begin
    if (tx_wr_en && busy_len > 0) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len - 1;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic push0(input logic [7:0] b);
    mem0[wr0[5:0]] = b;
    wr0 = wr0 + 1;
  endtask

  task automatic push1(input logic [7:0] b);
    mem1[wr1[5:0]] = b;
    wr1 = wr1 + 1;
  endtask

  task automatic do_reset();
    enable  = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #5;
    vectors++;
    if ({tx_wr_en, fifo0_rdreq, fifo1_rdreq, tx_src, err_timeout} !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {tx_wr_en, fifo0_rdreq, fifo1_rdreq, tx_src, err_timeout});
    end
    vectors++;
    if (tx_data !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_tx_data: got %h want 00", tx_data);
    end
    vectors++;
    if (byte_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_byte_cnt: got %h want 0000", byte_cnt);
    end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    int k;
    busy_len = 10;
    push0(8'hA5);
    tick();
    enable = 1'b1;                      // this cycle is the granting IDLE cycle
    tick();
    vectors++;
    if ({fifo0_rdreq, fifo1_rdreq, tx_wr_en, tx_src} !== 4'b1000) begin
      miscompares++;
      $display("FAIL single_read: rd0/rd1/wr/src got %b want 1000",
               {fifo0_rdreq, fifo1_rdreq, tx_wr_en, tx_src});
    end
    tick();
    vectors++;
    if ({fifo0_rdreq, fifo1_rdreq, tx_wr_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL single_latch: rd0/rd1/wr got %b want 000",
               {fifo0_rdreq, fifo1_rdreq, tx_wr_en});
    end
    tick();
    vectors++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL single_write: wr=%b data=%h want wr=1 data=a5", tx_wr_en, tx_data);
    end
    tick();
    vectors++;
    if (tx_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL single_wr_pulse: wr=%b want 0", tx_wr_en);
    end
    k = 0;
    while (byte_cnt == 16'd0 && k < 40) begin
      tick();
      k++;
    end
    vectors++;
    if (k != 11 || byte_cnt !== 16'd1) begin
      miscompares++;
      $display("FAIL single_done: cycles=%0d byte_cnt=%0d want cycles=11 byte_cnt=1", k, byte_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [6];
    logic       exp_src  [6];
    int nwr, both_hi, empty_rd;
    exp_data = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    exp_src  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    nwr = 0; both_hi = 0; empty_rd = 0;
    do_reset();
    busy_len = 3;
    push0(8'h10); push0(8'h11); push0(8'h12);
    push1(8'h20); push1(8'h21); push1(8'h22);
    tick();
    enable = 1'b1;
    for (int c = 0; c < 300 && byte_cnt != 16'd6; c++) begin
      tick();
      if (fifo0_rdreq && fifo1_rdreq) both_hi++;
      if ((fifo0_rdreq && fifo0_empty) || (fifo1_rdreq && fifo1_empty)) empty_rd++;
      if (tx_wr_en) begin
        if (nwr < 6) begin
          vectors++;
          if (tx_data !== exp_data[nwr] || tx_src !== exp_src[nwr]) begin
            miscompares++;
            $display("FAIL rr_byte%0d: data=%h src=%b want data=%h src=%b",
                     nwr, tx_data, tx_src, exp_data[nwr], exp_src[nwr]);
          end
        end
        nwr++;
      end
    end
    vectors++;
    if (byte_cnt !== 16'd6 || nwr != 6) begin
      miscompares++;
      $display("FAIL rr_count: byte_cnt=%0d writes=%0d want 6/6", byte_cnt, nwr);
    end
    vectors++;
    if (both_hi != 0 || empty_rd != 0) begin
      miscompares++;
      $display("FAIL rr_rdreq: both_high=%0d empty_reads=%0d want 0/0", both_hi, empty_rd);
    end
    enable = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    busy_len = 0;
    push1(8'h3C);
    tick();
    enable = 1'b1;
    for (int i = 0; i < 4; i++) tick();  // first WAIT_BUSY cycle
    vectors++;
    if (dut.state !== WAIT_BUSY) begin
      miscompares++;
      $display("FAIL to_entry: state=%0d want %0d", dut.state, WAIT_BUSY);
    end
    for (int i = 0; i < 7; i++) tick();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL to_early: err=%b want 0 after 7 cycles", err_timeout);
    end
    tick();
    vectors++;
    if (err_timeout !== 1'b1 || byte_cnt !== 16'd0 || dut.state !== IDLE) begin
      miscompares++;
      $display("FAIL to_set: err=%b byte_cnt=%0d state=%0d want 1/0/%0d",
               err_timeout, byte_cnt, dut.state, IDLE);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (err_timeout !== 1'b1 || tx_data !== 8'h3C || tx_src !== 1'b1) begin
      miscompares++;
      $display("FAIL to_hold: err=%b data=%h src=%b want 1/3c/1", err_timeout, tx_data, tx_src);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL to_clear: err=%b want 0", err_timeout);
    end
    // Timeout landing while err_clr is held: set must win.
    push1(8'h4D);
    err_clr = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    vectors++;
    if (err_timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL to_set_wins: err=%b want 1", err_timeout);
    end
    tick();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL to_clr_after: err=%b want 0", err_timeout);
    end
    err_clr  = 1'b0;
    enable   = 1'b0;
    busy_len = 10;
  endtask

  task automatic test_enable_drop();
    int k, rd;
    do_reset();
    busy_len = 10;
    push0(8'h55);
    push1(8'h66);
    tick();
    enable = 1'b1;
    k = 0;
    while (dut.state != WAIT_DONE && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (dut.state !== WAIT_DONE) begin
      miscompares++;
      $display("FAIL en_reach_done: state=%0d want %0d", dut.state, WAIT_DONE);
    end
    enable = 1'b0;
    k = 0;
    while (byte_cnt == 16'd0 && k < 30) begin
      tick();
      k++;
    end
    vectors++;
    if (byte_cnt !== 16'd1 || tx_data !== 8'h55) begin
      miscompares++;
      $display("FAIL en_counted: byte_cnt=%0d data=%h want 1/55", byte_cnt, tx_data);
    end
    rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fifo0_rdreq || fifo1_rdreq || tx_wr_en) rd++;
    end
    vectors++;
    if (rd != 0 || fifo1_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL en_hold: strobes=%0d fifo1_empty=%b want 0/0", rd, fifo1_empty);
    end
    enable = 1'b1;
    k = 0;
    while (!tx_wr_en && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'h66 || tx_src !== 1'b1) begin
      miscompares++;
      $display("FAIL en_resume: wr=%b data=%h src=%b want 1/66/1", tx_wr_en, tx_data, tx_src);
    end
    k = 0;
    while (byte_cnt == 16'd1 && k < 30) begin
      tick();
      k++;
    end
    vectors++;
    if (byte_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL en_second: byte_cnt=%0d want 2", byte_cnt);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, st;
    busy_len = 10;
    push0(8'h77);
    tick();
    enable = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (tx_wr_en !== 1'b1 || tx_data !== 8'h77) begin
      miscompares++;
      $display("FAIL rm_write: wr=%b data=%h want 1/77", tx_wr_en, tx_data);
    end
    #2;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    vectors++;
    if ({tx_wr_en, fifo0_rdreq, fifo1_rdreq, tx_src, err_timeout} !== 5'b00000 ||
        tx_data !== 8'h00 || byte_cnt !== 16'h0000) begin
      miscompares++;
      $display("FAIL rm_async: ctrl=%b data=%h byte_cnt=%h want 00000/00/0000",
               {tx_wr_en, fifo0_rdreq, fifo1_rdreq, tx_src, err_timeout}, tx_data, byte_cnt);
    end
    tick(); tick();
    reset_n = 1'b1;
    st = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_wr_en || fifo0_rdreq || fifo1_rdreq) st++;
    end
    vectors++;
    if (st != 0) begin
      miscompares++;
      $display("FAIL rm_no_glitch: strobes=%0d want 0", st);
    end
    push0(8'h88);
    tick();
    enable = 1'b1;
    k = 0;
    while (!tx_wr_en && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (k != 3 || tx_data !== 8'h88) begin
      miscompares++;
      $display("FAIL rm_fresh: cycles=%0d data=%h want 3/88", k, tx_data);
    end
    k = 0;
    while (byte_cnt == 16'd0 && k < 30) begin
      tick();
      k++;
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap();
    int k;
    busy_len = 10;
    force dut.byte_cnt_q = 16'hFFFF;
    tick();
    release dut.byte_cnt_q;
    tick();
    vectors++;
    if (byte_cnt !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: byte_cnt=%h want ffff", byte_cnt);
    end
    push1(8'h99);
    tick();
    enable = 1'b1;
    k = 0;
    while (byte_cnt == 16'hFFFF && k < 40) begin
      tick();
      k++;
    end
    vectors++;
    if (byte_cnt !== 16'h0000 || tx_data !== 8'h99 || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap: byte_cnt=%h data=%h err=%b want 0000/99/0", byte_cnt, tx_data, err_timeout);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter: BUSY_WAIT, default 8, max cycles in WAIT_BUSY for tx_busy to rise after tx_wr_en.
REQ-002 Parameter: DATA_W, default 8, byte width of FIFO and transmitter data.
REQ-003 clk_50m  input  1  sole clock, rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  level; 1 permits new byte grants.
REQ-006 err_clr  input  1  synchronous clear of err_timeout.
REQ-007 fifo0_empty, fifo1_empty  input  1 each  source FIFO empty flags.
REQ-008 fifo0_q, fifo1_q  input  DATA_W each  source FIFO read data; valid 1 cycle after rdreq (non-showahead).
REQ-009 fifo0_rdreq, fifo1_rdreq  output  1 each  single-cycle read strobes.
REQ-010 tx_busy  input  1  UART transmitter busy.
REQ-011 tx_wr_en  output  1  single-cycle transmitter load strobe.
REQ-012 tx_data  output  DATA_W  byte presented to transmitter.
REQ-013 tx_src  output  1  source of current/last byte (0 = fifo0, 1 = fifo1).
REQ-014 byte_cnt  output  16  completed-byte counter.
REQ-015 err_timeout  output  1  sticky busy-handshake error flag.

Function
REQ-016 FSM states: IDLE, READ, LATCH, WRITE, WAIT_BUSY, WAIT_DONE; registered state.
REQ-017 IDLE -> READ when enable=1, tx_busy=0, and at least one fifoN_empty=0; else stay in IDLE.
REQ-018 Grant is round-robin: if exactly one source is non-empty it wins; if both are non-empty, the source not served last wins; last-served pointer resets to 1, so fifo0 wins the first tie.
REQ-019 Grant is registered into tx_src on the IDLE -> READ transition.
REQ-020 READ: fifo[tx_src]_rdreq=1 for exactly one cycle; other rdreq=0; -> LATCH.
REQ-021 LATCH: tx_data <= fifo[tx_src]_q at end of cycle; -> WRITE.
REQ-022 WRITE: tx_wr_en=1 for exactly one cycle with tx_data stable; -> WAIT_BUSY.
REQ-023 Latency: tx_wr_en asserts exactly 3 cycles after the IDLE cycle that granted.
REQ-024 WAIT_BUSY: tx_busy=1 -> WAIT_DONE.
REQ-025 WAIT_BUSY timeout: after BUSY_WAIT cycles with tx_busy=0, set err_timeout, do not increment byte_cnt, -> IDLE.
REQ-026 WAIT_DONE: tx_busy=0 -> IDLE and byte_cnt increments by 1 in that cycle.
REQ-027 byte_cnt wraps 16'hFFFF -> 16'h0000 with no flag.
REQ-028 enable deasserted mid-transfer: the current byte completes through WAIT_DONE, then no further grant.
REQ-029 At most one rdreq is ever high; no rdreq is issued to an empty FIFO (empty is sampled in the granting IDLE cycle).
REQ-030 Back-to-back transfers: the IDLE cycle between WAIT_DONE and READ is mandatory (minimum 1 cycle).
REQ-031 err_timeout stays set until err_clr=1; if timeout and err_clr coincide, set wins.
REQ-032 tx_data and tx_src hold their last values while IDLE.

Reset
REQ-033 reset_n=0 asynchronously forces: state IDLE, tx_wr_en 0, both rdreq 0, tx_data 0, tx_src 0, byte_cnt 0, err_timeout 0, last-served pointer 1, timeout counter 0.
REQ-034 Reset asserted mid-transfer abandons the byte; no rdreq or tx_wr_en glitch on release.
REQ-035 Reset release is synchronized externally; the block adds no synchronizer.

Structure
REQ-036 Shared package holds the FSM state enumeration (3-bit encoding) and the DATA_W default.
REQ-037 Single module; the round-robin grant is one natural sub-module, rr_arb2 (2 requests, pointer in, grant out, combinational).

Verification
REQ-038 fifo0 holds 8'hA5, fifo1 empty, tx_busy model rises 1 cycle after wr_en and lasts 10 cycles -> fifo0_rdreq at cycle 1, tx_wr_en at cycle 3 with tx_data=8'hA5, byte_cnt=1.
REQ-039 Both FIFOs hold 3 bytes each -> grants alternate 0,1,0,1,0,1; byte_cnt=6; never two rdreq high together.
REQ-040 tx_busy never rises, BUSY_WAIT=8 -> err_timeout=1 eight cycles after WAIT_BUSY entry, byte_cnt unchanged, FSM in IDLE; err_clr pulse -> err_timeout=0.
REQ-041 enable dropped during WAIT_DONE with fifo1 non-empty -> current byte counted, no further rdreq until enable=1.
REQ-042 reset_n pulsed low in WRITE -> all outputs at reset values immediately; after release, no tx_wr_en until a fresh grant.
REQ-043 byte_cnt preloaded by forcing 16'hFFFF, one byte sent -> byte_cnt=16'h0000.
